// File: rtl/mips_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, mult/div operation
// codes and the mult/div sequencer states.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_LUI  = 4'd13,
    ALU_MFHI = 4'd14,
    ALU_MFLO = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MD_STEPS = 32;

  function automatic logic is_hilo_read(input logic [3:0] op);
    return (op == ALU_MFHI) || (op == ALU_MFLO);
  endfunction

endpackage

// File: rtl/execute_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one port.
interface execute_if;

  logic [1:0]  wb_ex;
  logic [1:0]  m_ex;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic        reg_dst;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] sign_ext_imm;
  logic [4:0]  shamt;
  logic [4:0]  rt;
  logic [4:0]  rd;

  logic [1:0]  wb_MEM;
  logic [1:0]  m;
  logic [31:0] address_MEM;
  logic [31:0] write_data_mem;
  logic [4:0]  write_register_ex;
  logic        stall;
  logic        ovf;
  mips_pkg::md_state_e md_state;

  // Flow control: stall is the only back-pressure. While it is high the ID side
  // must hold its instruction unchanged; the stage registers a bubble instead.
  modport master (
    output wb_ex, m_ex, alu_op, alu_src, reg_dst, md_start, md_op,
           read_data1, read_data2, sign_ext_imm, shamt, rt, rd,
    input  wb_MEM, m, address_MEM, write_data_mem, write_register_ex,
           stall, ovf, md_state
  );

  modport slave (
    input  wb_ex, m_ex, alu_op, alu_src, reg_dst, md_start, md_op,
           read_data1, read_data2, sign_ext_imm, shamt, rt, rd,
    output wb_MEM, m, address_MEM, write_data_mem, write_register_ex,
           stall, ovf, md_state
  );

endinterface

// File: rtl/muldiv.sv
// Iterative 32-step multiplier / restoring divider owning the HI/LO registers.
// Signed operations run on magnitudes and fix the signs when the result is written.
module muldiv
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output md_state_e   state
);

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic        is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d, dz_q, dz_d;

  logic        signed_op, sa, sb;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum, diff;
  logic [64:0] sh;
  logic [63:0] prod;
  logic [31:0] quo, rem, res_hi, res_lo;

  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    sa        = signed_op & a[31];
    sb        = signed_op & b[31];
    a_mag     = sa ? -a : a;
    b_mag     = sb ? -b : b;

    // acc holds {partial product, multiplier} or {remainder, quotient}
    sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    sh   = {acc_q, 1'b0};
    diff = sh[64:32] - {1'b0, b_q};

    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[31:0] : acc_q[31:0];
    rem  = rem_neg_q ? -acc_q[63:32] : acc_q[63:32];

    if (dz_q) begin
      res_hi = a_q;
      res_lo = 32'hFFFF_FFFF;
    end else if (is_div_q) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  assign busy  = (state_q == MD_BUSY);
  assign done  = busy && (dz_q || (cnt_q == 6'(MD_STEPS)));
  // New HI/LO are visible in the cycle they are written
  assign hi    = done ? res_hi : hi_q;
  assign lo    = done ? res_lo : lo_q;
  assign state = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d   = MD_BUSY;
          cnt_d     = '0;
          acc_d     = {32'd0, a_mag};
          a_d       = a;
          b_d       = b_mag;
          is_div_d  = op[1];
          dz_d      = op[1] && (b == 32'd0);
          neg_d     = sa ^ sb;
          rem_neg_d = sa;
        end
      end
      MD_BUSY: begin
        if (done) begin
          state_d = MD_IDLE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (is_div_q) acc_d = diff[32] ? sh[63:0] : {diff[31:0], sh[31:1], 1'b1};
          else          acc_d = {sum, acc_q[31:1]};
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
    end
  end

endmodule

// File: rtl/execute.sv
// MIPS execute stage: ALU, destination select, HI/LO via the mult/div unit and the
// EX/MEM pipeline register. Overflowing ADD/SUB and stalled cycles become bubbles.
module execute
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  execute_if.slave  ex
);

  logic [31:0] op_b, sum, diff, alu_res, hi, lo;
  logic        ovf_c, is_mf, md_busy, md_done, md_go, stall;
  md_state_e   md_state;

  logic [1:0]  wb_q, wb_d, m_q, m_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [4:0]  wreg_q, wreg_d;
  logic        ovf_q, ovf_d;

  assign op_b  = ex.alu_src ? ex.sign_ext_imm : ex.read_data2;
  assign sum   = ex.read_data1 + op_b;
  assign diff  = ex.read_data1 - op_b;
  assign is_mf = is_hilo_read(ex.alu_op);
  // MFHI/MFLO may pass in the write-back cycle thanks to the HI/LO bypass
  assign stall = md_busy && (ex.md_start || (is_mf && !md_done));
  assign md_go = ex.md_start && !stall;

  muldiv u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_go),
    .op    (ex.md_op),
    .a     (ex.read_data1),
    .b     (ex.read_data2),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (hi),
    .lo    (lo),
    .state (md_state)
  );

  always_comb begin
    alu_res = '0;
    ovf_c   = 1'b0;
    case (ex.alu_op)
      ALU_ADD: begin
        alu_res = sum;
        ovf_c   = (ex.read_data1[31] == op_b[31]) && (sum[31] != ex.read_data1[31]);
      end
      ALU_ADDU: alu_res = sum;
      ALU_SUB: begin
        alu_res = diff;
        ovf_c   = (ex.read_data1[31] != op_b[31]) && (diff[31] != ex.read_data1[31]);
      end
      ALU_SUBU: alu_res = diff;
      ALU_AND:  alu_res = ex.read_data1 & op_b;
      ALU_OR:   alu_res = ex.read_data1 | op_b;
      ALU_XOR:  alu_res = ex.read_data1 ^ op_b;
      ALU_NOR:  alu_res = ~(ex.read_data1 | op_b);
      ALU_SLT:  alu_res = {31'd0, $signed(ex.read_data1) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'd0, ex.read_data1 < op_b};
      ALU_SLL:  alu_res = ex.read_data2 << ex.shamt;
      ALU_SRL:  alu_res = ex.read_data2 >> ex.shamt;
      ALU_SRA:  alu_res = $unsigned($signed(ex.read_data2) >>> ex.shamt);
      ALU_LUI:  alu_res = {ex.sign_ext_imm[15:0], 16'h0000};
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    wb_d    = ex.wb_ex;
    m_d     = ex.m_ex;
    ovf_d   = ovf_c && !stall;
    addr_d  = alu_res;
    wdata_d = ex.read_data2;
    wreg_d  = ex.reg_dst ? ex.rd : ex.rt;
    if (stall || ovf_c) begin
      wb_d = 2'b00;
      m_d  = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q    <= '0;
      m_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wreg_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      m_q     <= m_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wreg_q  <= wreg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ex.wb_MEM            = wb_q;
  assign ex.m                 = m_q;
  assign ex.address_MEM       = addr_q;
  assign ex.write_data_mem    = wdata_q;
  assign ex.write_register_ex = wreg_q;
  assign ex.ovf               = ovf_q;
  assign ex.stall             = stall;
  assign ex.md_state          = md_state;

endmodule
